// File: rtl/mmio_bus_master.sv
// LSU-side initiator for the AR/R + AW/W MMIO bus: one access at a time,
// alignment check, per-phase stall watchdog and load-data extension.
module mmio_bus_master #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] arAddr,
    output logic [31:0] arWidth,
    output logic        arValid,
    input  logic        arReady,
    input  logic [31:0] rData,
    input  logic        rValid,
    output logic        rReady,
    output logic [31:0] wAddr,
    output logic [31:0] wData,
    output logic [31:0] wWidth,
    output logic        wValid,
    input  logic        wReady
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         width_q, width_d;
    logic [1:0]         size_q, size_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               bad_align;
    logic               wd_expire;
    logic [31:0]        rdata_ext;

    assign bad_align = (req_size == 2'd3)
                    || (req_size == 2'd1 && req_addr[0])
                    || (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    // TIMEOUT of zero turns the watchdog off entirely
    assign wd_expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        rdata_ext = rData;
        case (size_q)
            2'd0:    rdata_ext = {{24{sgn_q & rData[7]}},  rData[7:0]};
            2'd1:    rdata_ext = {{16{sgn_q & rData[15]}}, rData[15:0]};
            default: rdata_ext = rData;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        width_d = width_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    case (req_size)
                        2'd0:    begin width_d = 3'd1; wdata_d = {24'd0, req_wdata[7:0]};  end
                        2'd1:    begin width_d = 3'd2; wdata_d = {16'd0, req_wdata[15:0]}; end
                        default: begin width_d = 3'd4; wdata_d = req_wdata;                end
                    endcase
                    if (bad_align) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = req_write ? S_WRITE : S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (arReady) begin
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RDATA: begin
                if (rValid) begin
                    rdata_d = rdata_ext;
                    state_d = S_RESP;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (wReady) begin
                    state_d = S_RESP;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            width_q <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign arValid    = (state_q == S_RADDR);
    assign rReady     = (state_q == S_RDATA);
    assign wValid     = (state_q == S_WRITE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign arAddr     = addr_q;
    assign wAddr      = addr_q;
    assign wData      = wdata_q;
    assign arWidth    = {29'd0, width_q};
    assign wWidth     = {29'd0, width_q};

endmodule

// File: doc/mmio_bus_master.md
Name: mmio_bus_master

Overview:
- Initiator for the simple MMIO bus with channels AR/R (read) and AW/W (write); drives the DPI-backed MMIO responder from the CPU side.
- Accepts one load/store request at a time from the LSU on a valid/ready port.
- Checks alignment, runs the bus handshakes, and returns sign- or zero-extended read data or a write acknowledgement.
- Has a per-phase watchdog that reports an error if the bus stalls.

Parameters:
- TIMEOUT, 256, max cycles spent waiting in one bus phase before an error response; 0 disables the watchdog.
- CNT_W, 16, watchdog counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  1  LSU request valid
- req_ready  out  1  master can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  load sign-extends when 1
- resp_valid  out  1  response valid
- resp_ready  in  1  LSU accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or timeout
- arAddr  out  32  read address
- arWidth  out  32  read length in bytes (1/2/4)
- arValid  out  1  read address valid
- arReady  in  1  responder accepts read address
- rData  in  32  read data, low-aligned
- rValid  in  1  read data valid
- rReady  out  1  master accepts read data
- wAddr  out  32  write address
- wData  out  32  write data, bits above the access width zeroed
- wWidth  out  32  write length in bytes (1/2/4)
- wValid  out  1  write valid
- wReady  in  1  responder accepts write

Behaviour:
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Reset asserted (reset = 0), taking effect immediately:
  - state goes to IDLE, watchdog count to 0;
  - arValid, rReady, wValid, resp_valid and resp_err are all 0;
  - resp_rdata, arAddr, wAddr, wData = 0; arWidth, wWidth = 0;
  - req_ready = 1 once reset is released.
- Reset asserted mid-transaction abandons the transaction with no response; the responder must also be reset.
- States: IDLE, RADDR, RDATA, WRITE, RESP. req_ready = 1 only in IDLE.
- IDLE:
  - on req_valid = 1, latch addr, wdata, size, signed and write flag.
  - size = 3, half at an odd address, or word with addr[1:0] != 0 → RESP with resp_err = 1 and rdata = 0; no bus activity.
  - otherwise → RADDR for a load or WRITE for a store. Width is 1 << size; wData is masked to the width.
- RADDR: arValid = 1, arAddr/arWidth stable. On arReady = 1 in the same cycle → RDATA.
- RDATA: rReady = 1. On rValid = 1, capture rData and → RESP with err = 0.
  - byte: bits 7:0, extended by req_signed.
  - half: bits 15:0, extended by req_signed.
  - word: passed through unchanged.
- WRITE: wValid = 1 with wAddr/wData/wWidth held stable. On wReady = 1 → RESP with err = 0 and rdata = 0.
- RESP: resp_valid = 1 with data and err held. On resp_ready = 1 → IDLE. A new request can be accepted one cycle later; there is no back-to-back bypass.
- Watchdog:
  - counter clears on entry to RADDR, RDATA or WRITE;
  - it increments each cycle the phase's handshake does not occur;
  - when the count reaches TIMEOUT-1 with no handshake → RESP with err = 1, rdata = 0, and all bus valids drop next cycle.
  - a handshake in the same cycle as expiry wins: the transaction proceeds normally.
- Latency:
  - load with zero-wait responder: accept at t0, arValid t1, rReady t2, resp_valid t3 (rValid at t2).
  - store: accept t0, wValid t1, resp_valid t2.
  - misaligned/illegal request: resp_valid at t1.
- A response held while resp_ready = 0 stays stable indefinitely and is not subject to the watchdog.

Test Plan:
- Load byte, addr 0xA0000003, signed = 1, responder returns rData = 0x000000F0 → arWidth = 1, resp_rdata = 0xFFFFFFF0, err = 0; same access with signed = 0 → 0x000000F0.
- Store half, addr 0xA0000002, wdata 0xDEADBEEF → wAddr = 0xA0000002, wWidth = 2, wData = 0x0000BEEF, one write handshake, resp_valid with rdata = 0.
- Word load at 0x80000002 and size = 3 request → resp_err = 1 at t1, arValid/wValid never asserted.
- Responder holds arReady = 0, TIMEOUT = 8 → arValid held exactly 8 cycles, then resp_err = 1; arReady rising on the 8th cycle instead gives a normal read.
- Back-to-back load then store with resp_ready held low 5 cycles → response stable 5 cycles, req_ready = 0 until IDLE, second request issues only after.
- Assert reset during RDATA → rReady and resp_valid drop immediately; after release req_ready = 1 and a fresh word load at 0x80000000 completes correctly.
